instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Write-side companion of the fetch-stage instruction RAM. It receives a program as a byte stream
//  (from the UART/debug unit), packs big-endian 32-bit words and issues RAM write strobes.
//  It holds the pipeline halted while loading. On completion it pulses a CPU reset so PC restarts at 0.
// PARAMETERS
//  NB_BITS      32     instruction/data word width (must be 32)
//  RAM_DEPTH    10     word-address width of the instruction RAM (2**RAM_DEPTH words)
//  NB_LEN       16     width of the word-count header
//  TIMEOUT_CYC  1000   max idle cycles between bytes while loading before abort
// PORTS
//  i_clk         in   1          clock, all logic on rising edge
//  i_rst         in   1          synchronous reset, active-high
//  i_start       in   1          load command pulse
//  i_rx_data     in   8          received byte
//  i_rx_valid    in   1          1-cycle strobe, i_rx_data valid
//  o_wr_en       out  1          RAM write enable, 1-cycle pulse per word
//  o_wr_addr     out  RAM_DEPTH  RAM word address
//  o_wr_data     out  NB_BITS    RAM write data
//  o_cpu_halt    out  1          high = stall pipeline (PC/IF-ID write disabled)
//  o_cpu_rst     out  1          1-cycle pulse on successful completion
//  o_busy        out  1          high in LEN_HI, LEN_LO, DATA
//  o_done        out  1          level, high in DONE
//  o_err         out  2          00 none, 01 length overflow, 10 byte timeout; held until restart
//  o_word_cnt    out  NB_LEN     words written so far
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; internal byte index, timer and address cleared.
//  FSM: IDLE -> LEN_HI -> LEN_LO -> DATA -> DONE; any loading state -> ERROR.
//   IDLE: i_start moves to LEN_HI. An i_rx_valid in the same cycle is ignored. Bytes without start are dropped.
//   LEN_HI: a byte loads N[15:8]. LEN_LO: a byte loads N[7:0], then:
//     N==0 -> DONE (no writes, o_cpu_rst pulses); N > 2**RAM_DEPTH -> ERROR, o_err=01;
//     otherwise -> DATA, address=0, byte index=0.
//   DATA: first byte of word -> bits[31:24], last -> [7:0]. The 4th byte at cycle t gives
//     o_wr_en=1 at t+1, with o_wr_addr=word index and o_wr_data=packed word. o_word_cnt increments the same edge.
//     Bytes may arrive every cycle. Packing does not stall and accepts a byte during the write pulse.
//     The write of word N-1 moves the FSM to DONE in the same edge; o_cpu_rst=1 for the next cycle.
//   DONE: o_done=1, halt low. i_start restarts at LEN_HI and clears o_done, o_word_cnt and o_err.
//   ERROR: o_cpu_halt stays 1; o_wr_en never asserted; exits only via i_start (-> LEN_HI) or i_rst.
//  o_cpu_halt = 1 in LEN_HI, LEN_LO, DATA and ERROR; 0 in IDLE and DONE.
//  i_start while busy is ignored; it does not restart the load.
//  Timeout: counter clears on every i_rx_valid and on entry to LEN_HI, and increments in busy states.
//   Reaching TIMEOUT_CYC -> ERROR, o_err=10. A partial word is discarded; words already written are kept.
//  Address wraps never occur: the length check bounds the address to 2**RAM_DEPTH-1.
//  i_rst mid-load: IDLE next cycle. Halt drops, no o_cpu_rst pulse, no further writes.
// TESTING
//  1 start; bytes 00 02 | 20 08 00 05 | AC 08 00 04 -> wr(0,0x20080005), wr(1,0xAC080004), cpu_rst pulse, done=1
//  2 same stream with i_rx_valid every cycle -> identical writes, each wr_en exactly 1 cycle after 4th byte
//  3 start; 00 00 -> DONE, no wr_en, cpu_rst pulses once, halt low
//  4 RAM_DEPTH=10; header 04 01 (N=1025) -> ERROR, o_err=01, halt=1, zero writes; start recovers to LEN_HI
//  5 N=1, send 3 bytes then silence TIMEOUT_CYC cycles -> ERROR, o_err=10, no write issued
//  6 i_rst after 1st word written of N=3 -> IDLE, all outputs 0, halt low, no cpu_rst, later bytes dropped

Source files
------------

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader for the fetch-stage instruction RAM.
// Takes a 16-bit big-endian word count followed by big-endian 32-bit words.
// Issues one RAM write per completed word and holds the CPU halted while loading.
// On success it pulses a CPU reset; on overflow or byte timeout it parks in ERROR.
module instr_mem_loader #(
  parameter int unsigned NB_BITS     = 32,
  parameter int unsigned RAM_DEPTH   = 10,
  parameter int unsigned NB_LEN      = 16,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_wr_en,
  output logic [RAM_DEPTH-1:0] o_wr_addr,
  output logic [NB_BITS-1:0]   o_wr_data,
  output logic                 o_cpu_halt,
  output logic                 o_cpu_rst,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_err,
  output logic [NB_LEN-1:0]    o_word_cnt
);

  localparam int unsigned NB_SR   = NB_BITS - 8;
  localparam int unsigned NB_TMR  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned NB_LENX = NB_LEN + 1;
  localparam logic [NB_LENX-1:0] MAX_WORDS = NB_LENX'(2 ** RAM_DEPTH);
  localparam logic [NB_TMR-1:0]  TMR_LAST  = NB_TMR'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t              state;
  logic [NB_LEN-1:0]   len;
  logic [1:0]          byte_idx;
  logic [NB_SR-1:0]    word_sr;
  logic [RAM_DEPTH-1:0] addr;
  logic [NB_TMR-1:0]   timer;

  logic [NB_LEN-1:0]   len_full_c;
  logic [NB_LEN-1:0]   cnt_inc_c;

  // Full word count once the low header byte arrives; count after the pending write
  assign len_full_c = {len[NB_LEN-1:8], i_rx_data};
  assign cnt_inc_c  = o_word_cnt + NB_LEN'(1);

  // Loader FSM with registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      len        <= '0;
      byte_idx   <= '0;
      word_sr    <= '0;
      addr       <= '0;
      timer      <= '0;
      o_wr_en    <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_cpu_halt <= 1'b0;
      o_cpu_rst  <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= ERR_NONE;
      o_word_cnt <= '0;
    end else begin
      o_wr_en   <= 1'b0;
      o_cpu_rst <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          // Bytes arriving outside a load (or alongside start) are dropped
          if (i_start) begin
            state      <= ST_LEN_HI;
            timer      <= '0;
            o_busy     <= 1'b1;
            o_cpu_halt <= 1'b1;
            o_done     <= 1'b0;
            o_err      <= ERR_NONE;
            o_word_cnt <= '0;
          end
        end
        ST_LEN_HI, ST_LEN_LO, ST_DATA: begin
          if (i_rx_valid) begin
            timer <= '0;
            if (state == ST_LEN_HI) begin
              len   <= {i_rx_data, 8'h00};
              state <= ST_LEN_LO;
            end else if (state == ST_LEN_LO) begin
              len <= len_full_c;
              if (len_full_c == '0) begin
                state      <= ST_DONE;
                o_busy     <= 1'b0;
                o_cpu_halt <= 1'b0;
                o_done     <= 1'b1;
                o_cpu_rst  <= 1'b1;
              end else if ({1'b0, len_full_c} > MAX_WORDS) begin
                state  <= ST_ERROR;
                o_busy <= 1'b0;
                o_err  <= ERR_LEN;
              end else begin
                state    <= ST_DATA;
                addr     <= '0;
                byte_idx <= '0;
              end
            end else begin
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                o_wr_en    <= 1'b1;
                o_wr_addr  <= addr;
                o_wr_data  <= {word_sr, i_rx_data};
                addr       <= addr + RAM_DEPTH'(1);
                o_word_cnt <= cnt_inc_c;
                if (cnt_inc_c == len) begin
                  state      <= ST_DONE;
                  o_busy     <= 1'b0;
                  o_cpu_halt <= 1'b0;
                  o_done     <= 1'b1;
                  o_cpu_rst  <= 1'b1;
                end
              end else begin
                word_sr <= {word_sr[NB_SR-9:0], i_rx_data};
              end
            end
          end else if (timer == TMR_LAST) begin
            // Partial word is abandoned; words already written stay in RAM
            state  <= ST_ERROR;
            o_busy <= 1'b0;
            o_err  <= ERR_TIMEOUT;
          end else begin
            timer <= timer + NB_TMR'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected RAM writes are queued as bytes
// are driven and matched (address, data, cycle) when o_wr_en is observed.
module tb_instr_mem_loader;

  localparam int unsigned RAM_DEPTH   = 10;
  localparam int unsigned TIMEOUT_CYC = 1000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 wr_en;
  logic [RAM_DEPTH-1:0] wr_addr;
  logic [31:0]          wr_data;
  logic                 cpu_halt;
  logic                 cpu_rst;
  logic                 busy;
  logic                 done;
  logic [1:0]           err;
  logic [15:0]          word_cnt;

  typedef struct {
    logic [RAM_DEPTH-1:0] addr;
    logic [31:0]          data;
    int unsigned          cyc;
  } exp_wr_t;

  exp_wr_t     exp_q[$];
  int unsigned cyc = 0;
  int unsigned last_byte_cyc = 0;
  int unsigned rst_cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          wr_seen = 0;
  int          rst_seen = 0;

  instr_mem_loader #(
    .NB_BITS(32), .RAM_DEPTH(RAM_DEPTH), .NB_LEN(16), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_cpu_halt(cpu_halt),
    .o_cpu_rst(cpu_rst), .o_busy(busy), .o_done(done), .o_err(err), .o_word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: match every write against the scoreboard, log cpu reset pulses
  always @(posedge clk) begin : mon
    exp_wr_t e;
    #2;
    if (cpu_rst) begin
      rst_seen++;
      rst_cyc = cyc;
    end
    if (wr_en) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 64'(wr_addr), 64'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
        check("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    last_byte_cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      start    = 1'b0;
    end
  endtask

  task automatic pulse_start(input bit with_byte);
    @(negedge clk);
    start    = 1'b1;
    rx_valid = with_byte;
    rx_data  = 8'hFF;
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic send_header(input logic [15:0] n, input int gap);
    drive_byte(n[15:8]);
    if (gap > 0) idle(gap);
    drive_byte(n[7:0]);
    if (gap > 0) idle(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [RAM_DEPTH-1:0] a,
                           input bit expect_wr, input int gap);
    for (int i = 0; i < 4; i++) begin
      drive_byte(w[31-8*i -: 8]);
      if (i == 3 && expect_wr) exp_q.push_back('{a, w, cyc + 1});
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic check_idle(input string p);
    check({p, "_wr_en"},    64'(wr_en),    64'd0);
    check({p, "_wr_addr"},  64'(wr_addr),  64'd0);
    check({p, "_wr_data"},  64'(wr_data),  64'd0);
    check({p, "_halt"},     64'(cpu_halt), 64'd0);
    check({p, "_cpu_rst"},  64'(cpu_rst),  64'd0);
    check({p, "_busy"},     64'(busy),     64'd0);
    check({p, "_done"},     64'(done),     64'd0);
    check({p, "_err"},      64'(err),      64'd0);
    check({p, "_word_cnt"}, 64'(word_cnt), 64'd0);
  endtask

  initial begin
    int w_snap;
    int r_snap;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    // 1: gapped stream, stray byte before start, start while loading ignored
    drive_byte(8'h55);
    idle(2);
    check("t1_stray_busy", 64'(busy), 64'd0);
    pulse_start(1'b1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_halt", 64'(cpu_halt), 64'd1);
    send_header(16'd2, 1);
    pulse_start(1'b0);
    send_word(32'h2008_0005, 10'd0, 1'b1, 1);
    check("t1_cnt_mid", 64'(word_cnt), 64'd1);
    send_word(32'hAC08_0004, 10'd1, 1'b1, 1);
    check("t1_rst_pulse", 64'(cpu_rst), 64'd1);
    idle(3);
    check("t1_rst_cnt", 64'(rst_seen), 64'd1);
    check("t1_rst_cyc", 64'(rst_cyc), 64'(last_byte_cyc));
    check("t1_done", 64'(done), 64'd1);
    check("t1_halt_lo", 64'(cpu_halt), 64'd0);
    check("t1_word_cnt", 64'(word_cnt), 64'd2);
    check("t1_wr_cnt", 64'(wr_seen), 64'd2);

    // 2: same program, back-to-back bytes
    pulse_start(1'b0);
    check("t2_done_clr", 64'(done), 64'd0);
    check("t2_cnt_clr", 64'(word_cnt), 64'd0);
    send_header(16'd2, 0);
    send_word(32'h2008_0005, 10'd0, 1'b1, 0);
    send_word(32'hAC08_0004, 10'd1, 1'b1, 0);
    idle(3);
    check("t2_wr_cnt", 64'(wr_seen), 64'd4);
    check("t2_rst_cnt", 64'(rst_seen), 64'd2);
    check("t2_done", 64'(done), 64'd1);

    // 3: empty program
    pulse_start(1'b0);
    send_header(16'd0, 0);
    idle(1);
    check("t3_cpu_rst", 64'(cpu_rst), 64'd1);
    check("t3_done", 64'(done), 64'd1);
    check("t3_halt", 64'(cpu_halt), 64'd0);
    idle(3);
    check("t3_rst_cnt", 64'(rst_seen), 64'd3);
    check("t3_wr_cnt", 64'(wr_seen), 64'd4);

    // 4: length one past RAM size is rejected; exactly RAM size is accepted
    pulse_start(1'b0);
    send_header(16'h0401, 0);
    idle(1);
    check("t4_err", 64'(err), 64'd1);
    check("t4_halt", 64'(cpu_halt), 64'd1);
    check("t4_busy", 64'(busy), 64'd0);
    idle(5);
    check("t4_wr_cnt", 64'(wr_seen), 64'd4);
    pulse_start(1'b0);
    check("t4_recover_busy", 64'(busy), 64'd1);
    check("t4_recover_err", 64'(err), 64'd0);
    send_header(16'h0400, 0);
    idle(1);
    check("t4_max_busy", 64'(busy), 64'd1);
    check("t4_max_err", 64'(err), 64'd0);
    send_word(32'hDEAD_BEEF, 10'd0, 1'b1, 0);
    idle(TIMEOUT_CYC + 2);
    check("t4_max_timeout", 64'(err), 64'd2);
    check("t4_max_wr_cnt", 64'(wr_seen), 64'd5);

    // 5: partial word then silence
    pulse_start(1'b0);
    send_header(16'd1, 0);
    drive_byte(8'h11);
    drive_byte(8'h22);
    drive_byte(8'h33);
    idle(1);
    idle(TIMEOUT_CYC - 1);
    check("t5_err_before", 64'(err), 64'd0);
    idle(1);
    check("t5_err", 64'(err), 64'd2);
    check("t5_halt", 64'(cpu_halt), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_word_cnt", 64'(word_cnt), 64'd0);
    check("t5_wr_cnt", 64'(wr_seen), 64'd5);

    // 6: reset in the middle of a load
    pulse_start(1'b0);
    send_header(16'd3, 0);
    send_word(32'h0123_4567, 10'd0, 1'b1, 0);
    drive_byte(8'h89);
    drive_byte(8'hAB);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    r_snap = rst_seen;
    @(negedge clk);
    rst = 1'b0;
    check_idle("t6");
    w_snap = wr_seen;
    send_word(32'hCDEF_0011, 10'd1, 1'b0, 0);
    send_word(32'h2233_4455, 10'd1, 1'b0, 0);
    idle(4);
    check("t6_wr_cnt", 64'(wr_seen), 64'(w_snap));
    check("t6_wr_total", 64'(wr_seen), 64'd6);
    check("t6_rst_cnt", 64'(rst_seen), 64'(r_snap));
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_halt", 64'(cpu_halt), 64'd0);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
